// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory responder: RISC-V load/store
// funct3 encodings and the transaction FSM state encoding.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store enables and shifted data, load lane
// extraction with sign/zero extension, and alignment/type legality.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  dtype,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{offset, 3'b000} +: 8];
  assign half_sel = rword[{offset[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    bad        = 1'b0;
    case (dtype)
      DM_B, DM_BU: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (dtype == DM_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
        bad        = we && (dtype == DM_BU);
      end
      DM_H, DM_HU: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (dtype == DM_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        bad        = offset[0] || (we && (dtype == DM_HU));
      end
      DM_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        bad        = (offset != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable access latency: one outstanding
// transaction, side effects committed at acceptance, response held until taken.
module dmem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = $clog2(LATENCY + 1);
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  dm_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             bad;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      wdata_lane;
  logic [31:0]      rword;
  logic [31:0]      rdata_ext;

  assign idx          = req_addr[IDX_W+1:2];
  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign rword        = mem[idx];
  assign err          = bad || out_of_range;

  dm_lane_align u_align (
    .we         (req_we),
    .dtype      (req_type),
    .offset     (req_addr[1:0]),
    .wdata      (req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .bad        (bad)
  );

  // Next-state and latency counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(CNT_INIT);
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'd0 : rdata_ext;
      end
    end
  end

  // Storage array; cleared by reset, byte-lane writes at acceptance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (accept && req_we && !err) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata_lane[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed load/store scenarios plus
// random traffic against a byte-array reference model.
module tb_dmem_responder;
  import dm_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access rules applied arithmetically
  function automatic void model(input logic we, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    logic [31:0] v;
    er = 1'b0; rd = '0; size = 0; v = '0;
    case (t)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: begin size = 2; if (a % 2 != 0) er = 1'b1; end
      3'd2:       begin size = 4; if (a % 4 != 0) er = 1'b1; end
      default:    er = 1'b1;
    endcase
    if (we && (t == 3'd4 || t == 3'd5)) er = 1'b1;
    if (a / 4 >= DEPTH) er = 1'b1;
    if (er) return;
    for (int i = 0; i < size; i++) begin
      if (we) ref_mem[a + i] = wd[8*i +: 8];
      else    v = v | (32'(ref_mem[a + i]) << (8*i));
    end
    if (!we) begin
      if (t == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic txn(input string tag, input logic we, input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input logic early);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    model(we, t, a, wd, exp_rd, exp_err);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    rsp_ready = early;
    @(posedge clk); #1;
    // garbage request while busy must be ignored
    req_valid = 1'b1; req_we = 1'($urandom); req_type = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " rdata"}, rsp_rdata, exp_rd);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    if (!early) begin
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " hold rdata"}, rsp_rdata, exp_rd);
        check({tag, " hold err"}, 32'(rsp_err), 32'(exp_err));
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " valid after take"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready after take"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  rt;
    logic [31:0] ra;
    int          seen;

    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;

    #2 rstn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    txn("sw 0x10",      1'b1, DM_W,  32'h10, 32'h8765_4321, 0, 1'b0);
    txn("lw 0x10",      1'b0, DM_W,  32'h10, 32'h0, 0, 1'b0);
    txn("lb 0x13",      1'b0, DM_B,  32'h13, 32'h0, 0, 1'b0);
    txn("lbu 0x13",     1'b0, DM_BU, 32'h13, 32'h0, 0, 1'b0);
    txn("lh 0x12",      1'b0, DM_H,  32'h12, 32'h0, 0, 1'b0);
    txn("lhu 0x10",     1'b0, DM_HU, 32'h10, 32'h0, 0, 1'b0);
    txn("sb 0x11",      1'b1, DM_B,  32'h11, 32'hFFFF_FFAB, 0, 1'b0);
    txn("lw after sb",  1'b0, DM_W,  32'h10, 32'h0, 0, 1'b0);
    txn("sh 0x12",      1'b1, DM_H,  32'h12, 32'hCCCC_1234, 0, 1'b0);
    txn("lw after sh",  1'b0, DM_W,  32'h10, 32'h0, 0, 1'b0);
    txn("lw misalign",  1'b0, DM_W,  32'h12, 32'h0, 0, 1'b0);
    txn("sh misalign",  1'b1, DM_H,  32'h13, 32'h5555_5555, 0, 1'b0);
    txn("lw unchanged", 1'b0, DM_W,  32'h10, 32'h0, 0, 1'b0);
    txn("lw oor",       1'b0, DM_W,  32'(4*DEPTH), 32'h0, 0, 1'b0);
    txn("store t100",   1'b1, DM_BU, 32'h10, 32'h0000_00EE, 0, 1'b0);
    txn("lw type 011",  1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0);
    txn("lw backpress", 1'b0, DM_W,  32'h10, 32'h0, 5, 1'b0);
    txn("lw early rdy", 1'b0, DM_W,  32'h10, 32'h0, 0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      rt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1, 2, 3: ra = 32'($urandom_range(0, 4*DEPTH - 1));
        default: ra = 32'($urandom_range(0, 47));
      endcase
      txn("random", 1'($urandom), rt, ra, $urandom,
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
    end

    // Reset while a store is in flight
    txn("sw 0x20", 1'b1, DM_W, 32'h20, 32'hDEAD_BEEF, 0, 1'b0);
    txn("lw 0x20", 1'b0, DM_W, 32'h20, 32'h0, 0, 1'b0);
    check("pre-reset ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_type = DM_W;
    req_addr = 32'h20; req_wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    check("midreset rsp_rdata", rsp_rdata, 32'd0);
    check("midreset rsp_err", 32'(rsp_err), 32'd0);
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    @(negedge clk) rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("no rsp after reset", 32'(seen), 32'd0);
    txn("lw 0x20 cleared", 1'b0, DM_W, 32'h20, 32'h0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the memory-side end of the data-memory port, serving byte, halfword and word loads and stores with a valid/ready request channel and a valid/ready response channel. Access latency is programmable, so the core's load/store stall logic can be developed and verified against a slow memory. It sits after the MEM stage and replaces the zero-latency data memory when `LATENCY` > 0 behaviour is required.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid`; must be ≥ 1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_type`  in  3  RISC-V funct3 (DMType): 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] for sb, [15:0] for sh).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  load data, extended per `req_type`; 0 for stores and errors.
- `rsp_err`  out  1  access rejected (misaligned, out of range, or illegal type).

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE: `req_ready`=1. On `req_valid`, the request is accepted. Go to RESP if `LATENCY`=1; otherwise go to BUSY with the counter set to `LATENCY`-2.
- BUSY: `req_ready`=0. Decrement the counter. At 0, go to RESP.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable until `rsp_ready`=1, then go to IDLE.
- Memory side effects are committed at the acceptance edge:
  - A store writes only its byte lanes: sb writes lane `addr[1:0]`; sh writes lanes `{addr[1],0}` and `{addr[1],1}`; sw writes all four lanes.
  - A load samples the word at acceptance. It is then extended and registered into `rsp_rdata`.
- Extension rules:
  - lb and lh sign-extend from bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - lw passes the word through unchanged.
- An access is an error when any of the following holds: h/hu with `addr[0]`=1; w with `addr[1:0]`≠0; word index `addr[31:2]` ≥ `DEPTH_WORDS`; type 011/110/111; store with type 100/101.
  - On error, no array write occurs, `rsp_err`=1 and `rsp_rdata`=0.
- `req_*` inputs are ignored when `req_ready`=0. There is no queuing, so at most one transaction is outstanding.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0, all memory words 0.
- Acceptance at edge k gives `rsp_valid`=1 in the cycle after edge k+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance.
- Minimum throughput: one transaction per `LATENCY`+1 cycles.
  - The response handshake and a new acceptance never share a cycle, because `req_ready` is low in RESP.
- A load issued immediately after a store to the same word returns the stored bytes.
- Reset asserted mid-transaction:
  - Outputs return to reset values and the array is cleared.
  - The pending response is discarded; no response is produced after reset deasserts.
- If `rsp_ready` is held high while entering RESP, `rsp_valid` is still high for exactly one cycle.

## Structure
- Package `dm_pkg` holds:
  - the funct3 constants `DM_B`, `DM_H`, `DM_W`, `DM_BU`, `DM_HU`;
  - the state enum `dm_state_t` {IDLE, BUSY, RESP}.
- Sub-module `dm_lane_align` is purely combinational. It provides:
  - the store byte-enable and lane-shifted write data;
  - the load lane select with extension;
  - the misalignment and illegal-type flag.
- The top level holds the FSM, the latency counter, the array and the response registers.

## Test plan
- Reset, then sw 0x8765_4321 to 0x10, then lw 0x10 → `rsp_rdata`=0x8765_4321, `rsp_err`=0. With `LATENCY`=2, `rsp_valid` rises 2 cycles after each acceptance.
- After that store: lb 0x13 → 0xFFFF_FF87; lbu 0x13 → 0x0000_0087; lh 0x12 → 0xFFFF_8765; lhu 0x10 → 0x0000_4321.
- sb 0xAB to 0x11, then lw 0x10 → 0x8765_AB21. Then sh 0x1234 to 0x12, then lw 0x10 → 0x1234_AB21.
- Error cases:
  - lw 0x12 → `rsp_err`=1, `rsp_rdata`=0.
  - sh 0x13 → error; a following lw 0x10 is unchanged.
  - lw 4·`DEPTH_WORDS` → error.
  - store with type 100 → error.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and data are stable and `req_ready`=0 throughout. Release → IDLE next cycle.
- Reset mid-operation: assert `rstn`=0 during BUSY after an accepted sw → `rsp_valid` is never seen. After reset, lw of the same address → 0.
